// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo back-end types: reservation-station tags, data words, the
// CDB term and the source indices used by the CDB arbiter.
package data_types;

    typedef logic [31:0] word32_t;

    typedef enum logic [3:0] {
        NO_VAL,
        ALU_1, ALU_2, ALU_3, ALU_4,
        MUL_1, MUL_2, MUL_3, MUL_4,
        LS_1,  LS_2,  LS_3,  LS_4
    } rs_tag_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    localparam int NUM_CDB_SRC = 3;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_MULT,
        SRC_LSU
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_term_fifo.sv
// Per-source CDB term FIFO. The head is read combinationally from the array;
// a push on a full FIFO is only accepted when the same cycle pops.
module cdb_term_fifo
    import data_types::*;
#(
    parameter int DEPTH_POW2 = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic push_i,
    input  cdb_t data_i,
    input  logic pop_i,
    output cdb_t head_o,
    output logic empty_o,
    output logic full_o
);

    localparam int DEPTH = 1 << DEPTH_POW2;

    cdb_t                  mem [DEPTH];
    logic [DEPTH_POW2-1:0] wr_ptr_q;
    logic [DEPTH_POW2-1:0] rd_ptr_q;
    logic [DEPTH_POW2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (DEPTH_POW2+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem[rd_ptr_q];

    // Storage carries no reset; empty/full come from the control counters.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers one result term per source per cycle and
// broadcasts one buffered term per cycle, round-robin across sources.
module cdb_arbiter
    import data_types::*;
#(
    parameter int NUM_SRC         = NUM_CDB_SRC,
    parameter int FIFO_DEPTH_POW2 = 2
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  cdb_t               term_i [NUM_SRC],
    output logic [NUM_SRC-1:0] full_o,
    output cdb_t               cdb_o,
    output logic               overflow_o
);

    localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    cdb_t               head [NUM_SRC];
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] drop;
    logic [RR_W-1:0]    rr_q;
    logic [RR_W-1:0]    cand;
    logic [RR_W-1:0]    gnt_idx;
    logic               gnt_vld;
    cdb_t               cdb_p1;
    logic               overflow_q;

    // Stage p0: per-source FIFOs; a full FIFO still accepts when it is popped.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic term_vld;
        assign term_vld = (term_i[s].tag != NO_VAL);
        assign pop[s]   = gnt_vld && (gnt_idx == RR_W'(s));
        assign push[s]  = term_vld && (!fifo_full[s] || pop[s]);
        assign drop[s]  = term_vld && fifo_full[s] && !pop[s];

        cdb_term_fifo #(
            .DEPTH_POW2(FIFO_DEPTH_POW2)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_ni(reset_ni),
            .push_i  (push[s]),
            .data_i  (term_i[s]),
            .pop_i   (pop[s]),
            .head_o  (head[s]),
            .empty_o (empty[s]),
            .full_o  (fifo_full[s])
        );
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = RR_W'((int'(rr_q) + i) % NUM_SRC);
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Stage p1: registered broadcast, round-robin pointer and sticky overflow.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cdb_p1     <= '{tag: NO_VAL, val: '0};
            rr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (gnt_vld) begin
                cdb_p1 <= head[gnt_idx];
                rr_q   <= (gnt_idx == RR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                cdb_p1 <= '{tag: NO_VAL, val: '0};
            end
            if (|drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign cdb_o      = cdb_p1;
    assign full_o     = fifo_full;
    assign overflow_o = overflow_q;

endmodule
